// File: rtl/ux607_shadow_reg_vec.sv
`default_nettype none
// ============================================================================
//  Module   : ux607_shadow_reg_vec
//  Purpose  : Control/status register vector. It has byte-lane strobes and
//             write/set/clear/toggle operations. Writes go into a shadow copy,
//             and a commit moves the shadow into the active copy in one step.
//             An abort discards the pending shadow contents. With DIRECT=1
//             the shadow stage is bypassed.
//  Ports    : clock, reset        - clock, synchronous active-high reset
//             io_en/io_op/io_d    - write request, operation, data/mask
//             io_strb             - lane strobes (lane k = bits k*LANE +: LANE)
//             io_commit/io_abort  - publish / discard the shadow contents
//             io_q, io_shadow_q   - active and shadow copies
//             io_dirty            - shadow holds uncommitted writes
//             io_commit_ack       - one-cycle pulse after each commit
//             io_rise, io_fall    - per-bit edge pulses of the active copy
//  Revision : 1.0 - initial release
// ============================================================================
module ux607_shadow_reg_vec #(
  parameter int               WIDTH     = 32,
  parameter int               LANE      = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               DIRECT    = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_en,
  input  logic [1:0]            io_op,
  input  logic [WIDTH-1:0]      io_d,
  input  logic [WIDTH/LANE-1:0] io_strb,
  input  logic                  io_commit,
  input  logic                  io_abort,
  output logic [WIDTH-1:0]      io_q,
  output logic [WIDTH-1:0]      io_shadow_q,
  output logic                  io_dirty,
  output logic                  io_commit_ack,
  output logic [WIDTH-1:0]      io_rise,
  output logic [WIDTH-1:0]      io_fall
);

  localparam int LANES = WIDTH / LANE;

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  logic [WIDTH-1:0] active;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] q_d1;
  logic             dirty;
  logic             commit_ack;

  logic [WIDTH-1:0] lane_mask;
  logic [WIDTH-1:0] op_val;
  logic [WIDTH-1:0] shadow_next;
  logic             write_fire;

  // Expand each lane strobe across the bits of its lane.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_mask[k*LANE +: LANE] = {LANE{io_strb[k]}};
  end

  // A request with no strobed lane does nothing and does not mark dirty.
  assign write_fire = io_en && (|io_strb);

  always_comb begin
    op_val = shadow;
    case (io_op)
      OP_WRITE:  op_val = io_d;
      OP_SET:    op_val = shadow | io_d;
      OP_CLEAR:  op_val = shadow & ~io_d;
      OP_TOGGLE: op_val = shadow ^ io_d;
      default:   op_val = shadow;
    endcase
  end

  // Shadow including any same-cycle write. A commit publishes this value,
  // so a write and a commit in the same cycle act as one atomic update.
  always_comb begin
    shadow_next = shadow;
    if (write_fire) begin
      shadow_next = (shadow & ~lane_mask) | (op_val & lane_mask);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      active     <= RESET_VAL;
      shadow     <= RESET_VAL;
      q_d1       <= RESET_VAL;
      dirty      <= 1'b0;
      commit_ack <= 1'b0;
    end else begin
      q_d1       <= active;
      // Every accepted commit acks, so back-to-back commits hold ack high.
      commit_ack <= io_commit;
      if (DIRECT) begin
        // Bypass mode: both copies move together and never diverge.
        active <= shadow_next;
        shadow <= shadow_next;
        dirty  <= 1'b0;
      end else if (io_commit) begin
        // Commit takes priority over a simultaneous abort.
        active <= shadow_next;
        shadow <= shadow_next;
        dirty  <= 1'b0;
      end else if (io_abort) begin
        // A same-cycle write is dropped along with the pending contents.
        shadow <= active;
        dirty  <= 1'b0;
      end else begin
        shadow <= shadow_next;
        if (write_fire) begin
          dirty <= 1'b1;
        end
      end
    end
  end

  assign io_q          = active;
  assign io_shadow_q   = shadow;
  assign io_dirty      = dirty;
  assign io_commit_ack = commit_ack;
  // Edge pulses decode registered state only, so they last exactly one cycle.
  assign io_rise       = active & ~q_d1;
  assign io_fall       = ~active & q_d1;

endmodule
`default_nettype wire

// File: tb/tb_ux607_shadow_reg_vec.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ux607_shadow_reg_vec
//  Purpose  : Self-checking bench for ux607_shadow_reg_vec. A table of
//             per-cycle vectors drives the shadowed instance. A hand-written
//             sequence drives a DIRECT=1 instance.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ux607_shadow_reg_vec;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shadowed instance (RESET_VAL = 0xA5)
  logic        rst, en, commit, abort;
  logic [1:0]  op;
  logic [31:0] d;
  logic [3:0]  strb;
  logic [31:0] q, sh, rise, fall;
  logic        dirty, ack;

  ux607_shadow_reg_vec #(
    .WIDTH(32), .LANE(8), .RESET_VAL(32'h0000_00A5), .DIRECT(1'b0)
  ) dut (
    .clock(clk), .reset(rst), .io_en(en), .io_op(op), .io_d(d),
    .io_strb(strb), .io_commit(commit), .io_abort(abort),
    .io_q(q), .io_shadow_q(sh), .io_dirty(dirty), .io_commit_ack(ack),
    .io_rise(rise), .io_fall(fall)
  );

  // DIRECT=1 instance (RESET_VAL = 0)
  logic        rst2, en2, commit2, abort2;
  logic [1:0]  op2;
  logic [31:0] d2;
  logic [3:0]  strb2;
  logic [31:0] q2, sh2, rise2, fall2;
  logic        dirty2, ack2;

  ux607_shadow_reg_vec #(
    .WIDTH(32), .LANE(8), .RESET_VAL(32'h0), .DIRECT(1'b1)
  ) dut_direct (
    .clock(clk), .reset(rst2), .io_en(en2), .io_op(op2), .io_d(d2),
    .io_strb(strb2), .io_commit(commit2), .io_abort(abort2),
    .io_q(q2), .io_shadow_q(sh2), .io_dirty(dirty2), .io_commit_ack(ack2),
    .io_rise(rise2), .io_fall(fall2)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic [1:0]  op;
    logic [31:0] d;
    logic [3:0]  strb;
    logic        commit;
    logic        abort;
    logic [31:0] q;
    logic [31:0] sh;
    logic        dirty;
    logic        ack;
    logic [31:0] rise;
    logic [31:0] fall;
  } vec_t;

  localparam int NVEC = 26;
  vec_t vecs [NVEC];

  int checks   = 0;
  int failures = 0;

  function automatic vec_t mk(
    input logic rs, input logic e, input logic [1:0] o, input logic [31:0] dd,
    input logic [3:0] s, input logic c, input logic a,
    input logic [31:0] eq, input logic [31:0] esh, input logic edirty,
    input logic eack, input logic [31:0] er, input logic [31:0] ef);
    vec_t v;
    v.rst = rs; v.en = e; v.op = o; v.d = dd; v.strb = s; v.commit = c;
    v.abort = a; v.q = eq; v.sh = esh; v.dirty = edirty; v.ack = eack;
    v.rise = er; v.fall = ef;
    return v;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h expected=%h", name, idx, act, exp);
    end
  endtask

  task automatic drive_direct(input logic rs, input logic e, input logic [31:0] dd,
                              input logic c, input logic a);
    @(negedge clk);
    rst2 = rs; en2 = e; op2 = 2'b00; d2 = dd; strb2 = 4'hF;
    commit2 = c; abort2 = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst en op d strb commit abort | q sh dirty ack rise fall
    vecs[0]  = mk(1,0,2'b00,32'h0,4'h0,0,0, 32'h000000A5,32'h000000A5,0,0,32'h0,32'h0);
    vecs[1]  = mk(1,1,2'b00,32'hFFFFFFFF,4'hF,1,0, 32'h000000A5,32'h000000A5,0,0,32'h0,32'h0);
    vecs[2]  = mk(0,1,2'b00,32'hFFFFFFFF,4'hF,0,0, 32'h000000A5,32'hFFFFFFFF,1,0,32'h0,32'h0);
    vecs[3]  = mk(1,0,2'b00,32'h0,4'h0,0,0, 32'h000000A5,32'h000000A5,0,0,32'h0,32'h0);
    vecs[4]  = mk(0,1,2'b00,32'h0,4'hF,1,0, 32'h0,32'h0,0,1,32'h0,32'h000000A5);
    vecs[5]  = mk(0,0,2'b00,32'h0,4'h0,0,0, 32'h0,32'h0,0,0,32'h0,32'h0);
    vecs[6]  = mk(0,1,2'b00,32'h12345678,4'b0101,0,0, 32'h0,32'h00340078,1,0,32'h0,32'h0);
    vecs[7]  = mk(0,0,2'b00,32'h0,4'h0,1,0, 32'h00340078,32'h00340078,0,1,32'h00340078,32'h0);
    vecs[8]  = mk(0,0,2'b00,32'h0,4'h0,0,0, 32'h00340078,32'h00340078,0,0,32'h0,32'h0);
    vecs[9]  = mk(0,1,2'b00,32'h00FF00FF,4'hF,1,0, 32'h00FF00FF,32'h00FF00FF,0,1,32'h00CB0087,32'h0);
    vecs[10] = mk(0,1,2'b01,32'h0F000000,4'hF,1,0, 32'h0FFF00FF,32'h0FFF00FF,0,1,32'h0F000000,32'h0);
    vecs[11] = mk(0,1,2'b10,32'h000F000F,4'hF,0,0, 32'h0FFF00FF,32'h0FF000F0,1,0,32'h0,32'h0);
    vecs[12] = mk(0,1,2'b11,32'hFFFFFFFF,4'hF,0,0, 32'h0FFF00FF,32'hF00FFF0F,1,0,32'h0,32'h0);
    vecs[13] = mk(0,0,2'b00,32'h0,4'h0,1,0, 32'hF00FFF0F,32'hF00FFF0F,0,1,32'hF000FF00,32'h0FF000F0);
    vecs[14] = mk(0,0,2'b00,32'h0,4'h0,0,0, 32'hF00FFF0F,32'hF00FFF0F,0,0,32'h0,32'h0);
    vecs[15] = mk(0,1,2'b00,32'hAAAAAAAA,4'hF,1,0, 32'hAAAAAAAA,32'hAAAAAAAA,0,1,32'h0AA000A0,32'h50055505);
    vecs[16] = mk(0,1,2'b00,32'h55555555,4'hF,0,1, 32'hAAAAAAAA,32'hAAAAAAAA,0,0,32'h0,32'h0);
    vecs[17] = mk(0,1,2'b00,32'h55555555,4'hF,0,0, 32'hAAAAAAAA,32'h55555555,1,0,32'h0,32'h0);
    vecs[18] = mk(0,0,2'b00,32'h0,4'h0,0,1, 32'hAAAAAAAA,32'hAAAAAAAA,0,0,32'h0,32'h0);
    vecs[19] = mk(0,1,2'b00,32'h0F0F0F0F,4'b0011,0,0, 32'hAAAAAAAA,32'hAAAA0F0F,1,0,32'h0,32'h0);
    vecs[20] = mk(0,0,2'b00,32'h0,4'h0,1,1, 32'hAAAA0F0F,32'hAAAA0F0F,0,1,32'h00000505,32'h0000A0A0);
    vecs[21] = mk(0,0,2'b00,32'h0,4'h0,1,0, 32'hAAAA0F0F,32'hAAAA0F0F,0,1,32'h0,32'h0);
    vecs[22] = mk(0,0,2'b00,32'h0,4'h0,1,0, 32'hAAAA0F0F,32'hAAAA0F0F,0,1,32'h0,32'h0);
    vecs[23] = mk(0,1,2'b00,32'hFFFFFFFF,4'h0,0,0, 32'hAAAA0F0F,32'hAAAA0F0F,0,0,32'h0,32'h0);
    vecs[24] = mk(0,1,2'b00,32'hAAAA0F0F,4'hF,0,0, 32'hAAAA0F0F,32'hAAAA0F0F,1,0,32'h0,32'h0);
    vecs[25] = mk(1,1,2'b11,32'hFFFFFFFF,4'hF,1,0, 32'h000000A5,32'h000000A5,0,0,32'h0,32'h0);

    rst = 1'b1; en = 1'b0; op = 2'b00; d = '0; strb = '0; commit = 1'b0; abort = 1'b0;
    rst2 = 1'b1; en2 = 1'b0; op2 = 2'b00; d2 = '0; strb2 = '0; commit2 = 1'b0; abort2 = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; en = vecs[i].en; op = vecs[i].op; d = vecs[i].d;
      strb = vecs[i].strb; commit = vecs[i].commit; abort = vecs[i].abort;
      @(posedge clk);
      #1;
      chk("q",     i, q,  vecs[i].q);
      chk("shadow", i, sh, vecs[i].sh);
      chk("dirty", i, {31'b0, dirty}, {31'b0, vecs[i].dirty});
      chk("ack",   i, {31'b0, ack},   {31'b0, vecs[i].ack});
      chk("rise",  i, rise, vecs[i].rise);
      chk("fall",  i, fall, vecs[i].fall);
    end

    // DIRECT=1: writes land on both copies, dirty never set, abort inert,
    // commit only acks.
    drive_direct(1, 0, 32'h0, 0, 0);
    chk("direct_reset_q", 0, q2, 32'h0);
    chk("direct_reset_ack", 0, {31'b0, ack2}, 32'h0);
    drive_direct(0, 1, 32'h0000FFFF, 0, 0);
    chk("direct_q", 1, q2, 32'h0000FFFF);
    chk("direct_shadow", 1, sh2, 32'h0000FFFF);
    chk("direct_rise", 1, rise2, 32'h0000FFFF);
    chk("direct_dirty", 1, {31'b0, dirty2}, 32'h0);
    drive_direct(0, 0, 32'h0, 0, 1);
    chk("direct_rise_end", 2, rise2, 32'h0);
    chk("direct_abort_q", 2, q2, 32'h0000FFFF);
    chk("direct_abort_shadow", 2, sh2, 32'h0000FFFF);
    drive_direct(0, 0, 32'h0, 1, 0);
    chk("direct_ack", 3, {31'b0, ack2}, 32'h1);
    chk("direct_commit_q", 3, q2, 32'h0000FFFF);
    drive_direct(0, 1, 32'hFFFF0000, 0, 0);
    chk("direct_ack_end", 4, {31'b0, ack2}, 32'h0);
    chk("direct_q2", 4, q2, 32'hFFFF0000);
    chk("direct_fall", 4, fall2, 32'h0000FFFF);
    chk("direct_dirty2", 4, {31'b0, dirty2}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
